// File: rtl/ioc_spi_initiator_if.sv
// IOC register bus between the SPI initiator and its control modules.
// The initiator drives address, write data, selects and strobes; modules return read bytes.
`timescale 1ns/1ps
interface ioc_spi_initiator_if #(
  parameter int NUM_MODULES = 4
) ();
  logic [4:0]               ioc;
  logic [7:0]               data_out;
  logic [8*NUM_MODULES-1:0] data_in;
  logic [NUM_MODULES-1:0]   cs;
  logic                     fetch_cmd;
  logic                     load_cmd;

  modport master (
    output ioc, data_out, cs, fetch_cmd, load_cmd,
    input  data_in
  );

  modport slave (
    input  ioc, data_out, cs, fetch_cmd, load_cmd,
    output data_in
  );
endinterface

// File: rtl/ioc_spi_initiator.sv
// SPI mode-0 command front end driving the IOC register bus (opcode byte + data byte).
// Optional IOC_SPI_ECHO_EN: echo the previous completed opcode on MISO during the opcode byte.
`timescale 1ns/1ps
module ioc_spi_initiator #(
  parameter int NUM_MODULES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_sys_clk,
  input  logic                i_rst_b,
  input  logic                i_spi_sck,
  input  logic                i_spi_mosi,
  input  logic                i_spi_ss_b,
  output logic                o_spi_miso,
  output logic                o_spi_miso_oe,
  output logic                o_txn_err,
  ioc_spi_initiator_if.master bus
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_OPCODE   = 4'd1;
  localparam logic [3:0] ST_FETCH    = 4'd2;
  localparam logic [3:0] ST_WAIT     = 4'd3;
  localparam logic [3:0] ST_CAPTURE  = 4'd4;
  localparam logic [3:0] ST_DATA_OUT = 4'd5;
  localparam logic [3:0] ST_DATA_IN  = 4'd6;
  localparam logic [3:0] ST_LOAD     = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;

  function automatic logic sel_valid(input logic [1:0] sel);
    return (int'(sel) < NUM_MODULES);
  endfunction

  // Out-of-range selects map to an all-zero vector.
  function automatic logic [NUM_MODULES-1:0] sel_onehot(input logic [1:0] sel);
    logic [NUM_MODULES-1:0] oh;
    for (int k = 0; k < NUM_MODULES; k++) begin
      oh[k] = (int'(sel) == k);
    end
    return oh;
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] ss_sync_r;
  logic                   sck_prev_r;
  logic                   ss_prev_r;
  logic [1:0]             flush_cnt_r;
  logic                   armed_r;

  logic                   sck_s;
  logic                   mosi_s;
  logic                   ss_s;
  logic                   flush_done_s;
  logic                   sck_rise_s;
  logic                   sck_fall_s;
  logic                   ss_fall_s;
  logic                   in_txn_s;
  logic [7:0]             shift_word_s;
  logic [7:0]             rd_byte_s;

  logic [3:0]             state_r;
  logic [4:0]             bit_cnt_r;
  logic [6:0]             shift_in_r;
  logic [7:0]             miso_sr_r;
  logic [1:0]             sel_r;
  logic                   valid_r;
  logic                   err_done_r;
  logic [4:0]             ioc_r;
  logic [7:0]             data_out_r;
  logic [NUM_MODULES-1:0] cs_r;
  logic                   fetch_r;
  logic                   load_r;
  logic                   txn_err_r;
  logic                   miso_r;
  logic                   miso_oe_r;
`ifdef IOC_SPI_ECHO_EN
  logic [7:0]             opcode_r;
  logic [7:0]             echo_r;
`endif

  // Pin synchronisers, edge history and post-reset arming of SS_B fall detection.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      sck_sync_r  <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      ss_sync_r   <= {SYNC_STAGES{1'b1}};
      sck_prev_r  <= 1'b0;
      ss_prev_r   <= 1'b1;
      flush_cnt_r <= 2'd0;
      armed_r     <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], i_spi_sck};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], i_spi_mosi};
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], i_spi_ss_b};
      sck_prev_r  <= sck_s;
      ss_prev_r   <= ss_s;
      flush_cnt_r <= flush_done_s ? flush_cnt_r : flush_cnt_r + 2'd1;
      armed_r     <= armed_r | (flush_done_s & ss_s);
    end
  end

  // Edge detection, shift-word assembly and read-byte selection.
  always_comb begin
    sck_s        = sck_sync_r[SYNC_STAGES-1];
    mosi_s       = mosi_sync_r[SYNC_STAGES-1];
    ss_s         = ss_sync_r[SYNC_STAGES-1];
    flush_done_s = (flush_cnt_r == 2'(SYNC_STAGES));
    sck_rise_s   = sck_s & ~sck_prev_r;
    sck_fall_s   = ~sck_s & sck_prev_r;
    // A fall is only trusted once the chain holds real samples, so SS_B held low across reset is ignored.
    ss_fall_s    = armed_r & ss_prev_r & ~ss_s;
    in_txn_s     = (state_r != ST_IDLE) && (state_r != ST_LOAD) && (state_r != ST_DONE);
    shift_word_s = {shift_in_r, mosi_s};
    rd_byte_s    = 8'h00;
    for (int k = 0; k < NUM_MODULES; k++) begin
      rd_byte_s = rd_byte_s | (bus.data_in[8*k +: 8] & {8{int'(sel_r) == k}});
    end
  end

  // Transaction FSM with registered bus, strobe and MISO outputs.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 5'd0;
      shift_in_r <= 7'd0;
      miso_sr_r  <= 8'h00;
      sel_r      <= 2'd0;
      valid_r    <= 1'b0;
      err_done_r <= 1'b0;
      ioc_r      <= 5'd0;
      data_out_r <= 8'h00;
      cs_r       <= {NUM_MODULES{1'b0}};
      fetch_r    <= 1'b0;
      load_r     <= 1'b0;
      txn_err_r  <= 1'b0;
      miso_r     <= 1'b0;
      miso_oe_r  <= 1'b0;
`ifdef IOC_SPI_ECHO_EN
      opcode_r   <= 8'h00;
      echo_r     <= 8'h00;
`endif
    end else begin
      cs_r      <= {NUM_MODULES{1'b0}};
      fetch_r   <= 1'b0;
      load_r    <= 1'b0;
      txn_err_r <= 1'b0;
      miso_oe_r <= ~ss_s;
      if (ss_s && in_txn_s) begin
        state_r   <= ST_IDLE;
        miso_r    <= 1'b0;
        txn_err_r <= ~err_done_r;
      end else begin
        case (state_r)
          ST_IDLE: begin
            miso_r <= 1'b0;
            if (ss_fall_s) begin
              state_r    <= ST_OPCODE;
              bit_cnt_r  <= 5'd0;
              err_done_r <= 1'b0;
`ifdef IOC_SPI_ECHO_EN
              miso_r     <= echo_r[7];
              miso_sr_r  <= {echo_r[6:0], 1'b0};
`else
              miso_sr_r  <= 8'h00;
`endif
            end
          end
          ST_OPCODE: begin
            if (sck_rise_s) begin
              shift_in_r <= shift_word_s[6:0];
              bit_cnt_r  <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == 5'd7) begin
                ioc_r   <= shift_word_s[4:0];
                sel_r   <= shift_word_s[6:5];
                valid_r <= sel_valid(shift_word_s[6:5]);
                miso_r  <= 1'b0;
`ifdef IOC_SPI_ECHO_EN
                opcode_r <= shift_word_s;
`endif
                if (shift_word_s[7]) begin
                  state_r <= ST_DATA_IN;
                end else begin
                  state_r    <= ST_FETCH;
                  cs_r       <= sel_onehot(shift_word_s[6:5]);
                  fetch_r    <= sel_valid(shift_word_s[6:5]);
                  txn_err_r  <= ~sel_valid(shift_word_s[6:5]);
                  err_done_r <= ~sel_valid(shift_word_s[6:5]);
                end
              end
            end else if (sck_fall_s && (bit_cnt_r != 5'd0)) begin
              miso_r    <= miso_sr_r[7];
              miso_sr_r <= {miso_sr_r[6:0], 1'b0};
            end
          end
          ST_FETCH: begin
            state_r <= ST_WAIT;
          end
          ST_WAIT: begin
            state_r <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            miso_r    <= rd_byte_s[7];
            miso_sr_r <= {rd_byte_s[6:0], 1'b0};
            state_r   <= ST_DATA_OUT;
          end
          ST_DATA_OUT: begin
            // Bit 7 is already on MISO; the fall right after rise 8 must not shift it away.
            if (sck_rise_s) begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == 5'd15) begin
                state_r <= ST_DONE;
`ifdef IOC_SPI_ECHO_EN
                echo_r  <= opcode_r;
`endif
              end
            end else if (sck_fall_s && (bit_cnt_r > 5'd8)) begin
              miso_r    <= miso_sr_r[7];
              miso_sr_r <= {miso_sr_r[6:0], 1'b0};
            end
          end
          ST_DATA_IN: begin
            if (sck_rise_s) begin
              shift_in_r <= shift_word_s[6:0];
              bit_cnt_r  <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == 5'd15) begin
                state_r    <= ST_LOAD;
                data_out_r <= shift_word_s;
                cs_r       <= sel_onehot(sel_r);
                load_r     <= valid_r;
                txn_err_r  <= ~valid_r;
                err_done_r <= ~valid_r;
              end
            end
          end
          ST_LOAD: begin
            state_r <= ST_DONE;
`ifdef IOC_SPI_ECHO_EN
            echo_r  <= opcode_r;
`endif
          end
          ST_DONE: begin
            if (ss_s) begin
              state_r <= ST_IDLE;
              miso_r  <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            miso_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ioc       = ioc_r;
  assign bus.data_out  = data_out_r;
  assign bus.cs        = cs_r;
  assign bus.fetch_cmd = fetch_r;
  assign bus.load_cmd  = load_r;
  assign o_spi_miso    = miso_r;
  assign o_spi_miso_oe = miso_oe_r;
  assign o_txn_err     = txn_err_r;

endmodule

// File: tb/tb_ioc_spi_initiator.sv
// Randomised transaction-level bench for ioc_spi_initiator with a host SPI driver and bus monitor.
`timescale 1ns/1ps
module tb_ioc_spi_initiator;
  localparam int N_MOD = 2;
  localparam int HALF  = 100;

  logic clk = 1'b0;
  logic rst_b, sck, mosi, ss_b;
  logic miso, miso_oe, txn_err;
  logic [8*N_MOD-1:0] din;

  always #5 clk = ~clk;

  ioc_spi_initiator_if #(.NUM_MODULES(N_MOD)) bus_if ();
  assign bus_if.data_in = din;

  ioc_spi_initiator #(.NUM_MODULES(N_MOD), .SYNC_STAGES(2)) dut (
    .i_sys_clk     (clk),
    .i_rst_b       (rst_b),
    .i_spi_sck     (sck),
    .i_spi_mosi    (mosi),
    .i_spi_ss_b    (ss_b),
    .o_spi_miso    (miso),
    .o_spi_miso_oe (miso_oe),
    .o_txn_err     (txn_err),
    .bus           (bus_if)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: cycle counts of each strobe and of protocol violations.
  int fetch_n = 0, load_n = 0, err_n = 0, bad_n = 0;
  logic [N_MOD-1:0] cs_last = '0;
  always @(negedge clk) begin
    if (bus_if.fetch_cmd) fetch_n <= fetch_n + 1;
    if (bus_if.load_cmd)  load_n  <= load_n + 1;
    if (txn_err)          err_n   <= err_n + 1;
    if (bus_if.cs != '0)  cs_last <= bus_if.cs;
    if (((bus_if.cs != '0) != (bus_if.fetch_cmd | bus_if.load_cmd)) ||
        (bus_if.fetch_cmd & bus_if.load_cmd) || ($countones(bus_if.cs) > 1))
      bad_n <= bad_n + 1;
  end

  // Reference state: what the bus should hold and the last completed opcode.
  logic [4:0] m_ioc  = 5'd0;
  logic [7:0] m_dout = 8'h00;
  logic [7:0] m_echo = 8'h00;

  function automatic logic [31:0] out_word();
    return {11'd0, bus_if.ioc, bus_if.data_out, bus_if.cs, bus_if.fetch_cmd,
            bus_if.load_cmd, txn_err, miso, miso_oe};
  endfunction

  task automatic run_txn(input logic [7:0] op, input logic [7:0] dat, input int rises,
                         input int extra, input bit rst_mid, input bit sck_hi);
    int f0, l0, e0, b0;
    logic [15:0] miso_bits;
    logic [N_MOD-1:0] exp_cs;
    logic [7:0] exp_rd, exp_echo;
    bit rd, ok, done, aborted, oe_ok;
    int exp_fetch, exp_load, exp_err;
    rd = ~op[7];
    ok = (int'(op[6:5]) < N_MOD);
    done = (rises == 16) && !rst_mid;
    aborted = (rises < 16) && !rst_mid;
    exp_cs = N_MOD'(32'd1 << op[6:5]);
    exp_rd = ok ? 8'(din >> (8 * int'(op[6:5]))) : 8'h00;
`ifdef IOC_SPI_ECHO_EN
    exp_echo = m_echo;
`else
    exp_echo = 8'h00;
`endif
    f0 = fetch_n; l0 = load_n; e0 = err_n; b0 = bad_n;
    miso_bits = 16'h0000;
    oe_ok = 1'b1;
    if (sck_hi) begin sck = 1'b1; #HALF; end
    ss_b = 1'b0;
    #HALF;
    if (sck_hi) begin sck = 1'b0; #HALF; end
    for (int i = 0; i < rises; i++) begin
      mosi = (i < 8) ? op[7 - i] : dat[15 - i];
      #HALF;
      miso_bits[15 - i] = miso;
      if (!miso_oe) oe_ok = 1'b0;
      sck = 1'b1;
      if (rst_mid && (i == rises - 1)) begin
        #20;
        rst_b = 1'b0;
        #1;
        chk("reset_mid_outputs", out_word(), 32'd0);
      end
      #HALF;
      sck = 1'b0;
    end
    if (rst_mid) begin
      ss_b = 1'b1; mosi = 1'b0;
      #50;
      rst_b = 1'b1;
      m_ioc = 5'd0; m_dout = 8'h00; m_echo = 8'h00;
      @(posedge clk); #3;
      #(4 * HALF);
      chk("reset_no_load", load_n - l0, 0);
      chk("reset_no_err", err_n - e0, 0);
      return;
    end
    #HALF;
    repeat (extra) begin sck = 1'b1; #HALF; sck = 1'b0; #HALF; end
    chk("miso_oe_active", oe_ok, 1);
    ss_b = 1'b1;
    #(4 * HALF);
    chk("miso_oe_idle", miso_oe, 0);

    exp_fetch = (rd && ok && rises >= 8) ? 1 : 0;
    exp_load  = (!rd && ok && done) ? 1 : 0;
    exp_err   = (aborted || (!ok && (rd ? (rises >= 8) : done))) ? 1 : 0;
    if (rises >= 8) m_ioc = op[4:0];
    if (done && !rd) m_dout = dat;
    chk("fetch_pulses", fetch_n - f0, exp_fetch);
    chk("load_pulses", load_n - l0, exp_load);
    chk("txn_err_pulses", err_n - e0, exp_err);
    chk("strobe_rules", bad_n - b0, 0);
    chk("ioc", bus_if.ioc, m_ioc);
    chk("data_out", bus_if.data_out, m_dout);
    if (exp_fetch + exp_load > 0) chk("cs_select", cs_last, exp_cs);
    if (rises >= 8) chk("miso_opcode_byte", miso_bits[15:8], exp_echo);
    if (done && rd) chk("miso_read_byte", miso_bits[7:0], exp_rd);
    if (done) m_echo = op;
  endtask

  initial begin
    logic [7:0] r_op, r_dat;
    int r_rises;
    rst_b = 1'b0; sck = 1'b0; mosi = 1'b0; ss_b = 1'b1; din = '0;
    #23;
    chk("reset_outputs", out_word(), 32'd0);
    #20;
    rst_b = 1'b1;
    @(posedge clk); #3;
    #(2 * HALF);

    din = 16'h0001;
    run_txn(8'h00, 8'h00, 16, 0, 1'b0, 1'b0);
    run_txn(8'h86, 8'hA5, 16, 1, 1'b0, 1'b0);
    run_txn(8'hC1, 8'h55, 16, 0, 1'b0, 1'b0);
    run_txn(8'h41, 8'h00, 16, 0, 1'b0, 1'b0);
    run_txn(8'h87, 8'h0F, 12, 0, 1'b0, 1'b0);
    run_txn(8'h86, 8'h33, 16, 0, 1'b0, 1'b0);
    din = 16'h3C01;
    run_txn(8'h20, 8'h00, 16, 0, 1'b0, 1'b0);
    run_txn(8'hA7, 8'h0A, 16, 2, 1'b0, 1'b0);
    run_txn(8'h21, 8'h00, 16, 0, 1'b0, 1'b1);
    run_txn(8'h85, 8'hEE, 10, 0, 1'b1, 1'b0);
    run_txn(8'h85, 8'h01, 16, 0, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      din = N_MOD*8'($urandom);
      r_op = 8'($urandom);
      r_dat = 8'($urandom);
      r_rises = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      run_txn(r_op, r_dat, r_rises, (r_rises == 16) ? int'($urandom_range(0, 2)) : 0,
              1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ioc_spi_initiator.md
Name: ioc_spi_initiator

Overview:
- Host-facing SPI command front end (SPI mode 0, MSB first) that drives the shared IOC register bus to the control modules (sys_ctrl, io_ctrl, smi_ctrl, …).
- Each transaction is 16 SCK cycles: an opcode byte followed by a data byte.
- It decodes the opcode, asserts the selected module's chip-select with a one-cycle fetch or load strobe, and returns read data on MISO.
- SPI pins are oversampled in the i_sys_clk domain; no second clock domain.

Parameters:
- NUM_MODULES, 4, number of IOC slave modules; width of o_cs; valid range 1..4.
- SYNC_STAGES, 2, synchroniser depth on SCK/MOSI/SS_B; valid range 2..3.

Ports:
- i_sys_clk  in  1  system clock; must be ≥16× SCK frequency.
- i_rst_b  in  1  reset.
- i_spi_sck  in  1  host SPI clock, idle low.
- i_spi_mosi  in  1  host data in.
- i_spi_ss_b  in  1  host slave select, active low.
- o_spi_miso  out  1  data to host.
- o_spi_miso_oe  out  1  MISO output enable.
- o_ioc  out  5  IOC address to modules.
- o_data_out  out  8  write data to modules (their i_data_in).
- i_data_in  in  8*NUM_MODULES  module o_data_out buses; module k on bits [8k+7:8k].
- o_cs  out  NUM_MODULES  one-hot module select.
- o_fetch_cmd  out  1  read strobe.
- o_load_cmd  out  1  write strobe.
- o_txn_err  out  1  one-cycle pulse on an aborted or invalid transaction.

Interface decision: reset i_rst_b, asynchronous, active-low; clock i_sys_clk.

Behaviour:
- Reset values: o_ioc=0, o_data_out=0, o_cs=0, o_fetch_cmd=0, o_load_cmd=0, o_txn_err=0, o_spi_miso=0, o_spi_miso_oe=0. FSM=IDLE, bit counter=0.
- Synchronisers: SCK, MOSI and SS_B each pass through SYNC_STAGES flops. SCK rise/fall are detected by comparing the last two synchronised samples.
- Sampling: MOSI is sampled on each synchronised SCK rise. MISO shifts on each synchronised SCK fall, and only in the DATA state.
- Opcode byte: bit7 selects direction (1=write/load, 0=read/fetch); bits6:5 = module select; bits4:0 = IOC.
- Validity: select ≥ NUM_MODULES marks the transaction invalid.
- o_spi_miso_oe = 1 exactly while synchronised SS_B is low.
- FSM states:
  - IDLE: SS_B fall → OPCODE, counter=0.
  - OPCODE: shift in 8 bits. On the 8th rise, latch o_ioc and the select. Read → FETCH; write → DATA_IN.
  - FETCH (1 cycle): o_cs[sel]=1, o_fetch_cmd=1. Invalid select: no cs, no strobe.
  - WAIT (1 cycle): module registers its output.
  - CAPTURE (1 cycle): load the MISO shift register with i_data_in[sel]. Invalid select loads 0x00. o_spi_miso = bit7 → DATA_OUT.
  - DATA_OUT: shift MISO on 7 falls, continue counting rises; 16th rise → DONE.
  - DATA_IN: shift MOSI; 16th rise → LOAD.
  - LOAD (1 cycle): o_data_out = received byte (registered in the same edge); o_cs[sel]=1 and o_load_cmd=1 in that same cycle. Invalid select: no strobe, o_txn_err pulse. → DONE.
  - DONE: ignore SCK until SS_B rises → IDLE.
- Strobe rules: o_cs, o_fetch_cmd and o_load_cmd are each high for exactly one i_sys_clk cycle, never together. o_ioc and o_data_out hold their values until the next transaction.
- Read timing: FETCH through CAPTURE completes within 4 sys clocks of the 8th rise, i.e. before the 9th SCK rise at the ≥16× clock ratio.
- Abort: SS_B rises before the 16th rise → IDLE, o_txn_err pulse 1 cycle, no load strobe. A fetch already issued is not undone; fetch is side-effect-free.
- Extra SCK: edges beyond 16 in DONE are ignored; no second command.
- SS_B low with SCK already high at entry: the first rise counts only after SS_B falls.
- Reset mid-transaction: all outputs return to reset values immediately. The next transaction needs a fresh SS_B fall.

Optional Feature:
- Macro: IOC_SPI_ECHO_EN.
- Defined: during OPCODE, MISO shifts out (on falls, MSB first) the opcode of the previous completed transaction, for host link checking. Initial value after reset is 0x00.
- Undefined: MISO = 0 throughout OPCODE; no echo register.

Test Plan:
- Read sys_ctrl module version: opcode 0x00, data 0x00 → one-cycle o_cs=4'b0001 and o_fetch_cmd, o_ioc=5'h00; with i_data_in[7:0]=0x01, MISO byte 2 = 0x01.
- Write: opcode 0x86 (sel 0, IOC 6), data 0xA5 → single cycle with o_cs=4'b0001, o_load_cmd=1, o_data_out=0xA5, o_ioc=5'h06; no fetch pulse.
- Invalid select with NUM_MODULES=2: opcode 0xC1, data 0x55 → no cs/load, o_txn_err pulses once. Read 0x41 → MISO 0x00.
- Abort: SS_B rises after 12 SCK of write 0x87/0x0F → o_txn_err pulse, no o_load_cmd, FSM IDLE; following valid write completes normally.
- Back-to-back: read of sel 1 (opcode 0x20, i_data_in[15:8]=0x3C) then write 0xA7/0x0A with 2 SCK periods of SS_B high → MISO 0x3C, then a single load strobe with o_cs=4'b0010 and o_data_out=0x0A. With IOC_SPI_ECHO_EN, MISO in the 2nd opcode byte = 0x20.
- Reset asserted at SCK edge 10 of a write → all outputs 0 immediately, no load strobe; after release, transaction 0x85/0x01 loads correctly.
